// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, clocked data shift and device
// acknowledge check, with open-drain enables for the clock and data lines.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 9600,
  parameter int TIMEOUT_CYC = 1440000,
  parameter int FILTER      = 8
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CYC_MAX = (INHIBIT_CYC > 16) ? INHIBIT_CYC : 16;
  localparam int CW      = $clog2(CYC_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);
  localparam int FW      = $clog2(FILTER + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

  state_t        state, state_next;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt, clk_filt_d;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [9:0]    shreg;
  logic [3:0]    bitcnt;
  logic [CW-1:0] cyc_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          dat_bit, err_flag, busy_q, err_q;
  logic          accept, cyc_clr, start_send, shift, ack_sample, finish, timeout_hit;

  // Idle line is high, so synchronisers and filter come out of reset at 1.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_s1     <= ps2_clk_in;
      clk_s2     <= clk_s1;
      dat_s1     <= ps2_dat_in;
      dat_s2     <= dat_s1;
      clk_filt_d <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  assign timeout_hit = ((state == SEND) || (state == ACK) || (state == WAIT_IDLE)) &&
                       (tmo_cnt == TW'(TIMEOUT_CYC));

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    cyc_clr    = 1'b0;
    start_send = 1'b0;
    shift      = 1'b0;
    ack_sample = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start) begin
          accept     = 1'b1;
          state_next = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cyc_cnt == CW'(INHIBIT_CYC - 1)) begin
          cyc_clr    = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (cyc_cnt == CW'(15)) begin
          start_send = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (fall) begin
          shift = 1'b1;
          if (bitcnt == 4'd9) state_next = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          ack_sample = 1'b1;
          state_next = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_filt && dat_s2) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // An expired transfer abandons whatever the bit engine was doing this cycle.
    if (timeout_hit) begin
      shift      = 1'b0;
      ack_sample = 1'b0;
      finish     = 1'b1;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      cyc_cnt  <= '0;
      tmo_cnt  <= '0;
      dat_bit  <= 1'b0;
      err_flag <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;

      if (accept || cyc_clr) begin
        cyc_cnt <= '0;
      end else if (((state == INHIBIT) || (state == REQ)) && (cyc_cnt != CW'(CYC_MAX))) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end

      if (start_send) begin
        tmo_cnt <= '0;
      end else if (((state == SEND) || (state == ACK) || (state == WAIT_IDLE)) &&
                   (tmo_cnt != TW'(TIMEOUT_CYC))) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      // Frame is stop, odd parity, data; shifted out LSB first.
      if (accept) begin
        shreg <= {1'b1, ~^tx_data, tx_data};
      end else if (shift) begin
        shreg <= {1'b0, shreg[9:1]};
      end

      if (start_send) begin
        bitcnt  <= '0;
        dat_bit <= 1'b1;
      end else if (shift) begin
        bitcnt  <= bitcnt + 1'b1;
        dat_bit <= ~shreg[0];
      end

      if (accept) begin
        err_flag <= 1'b0;
      end else if (ack_sample) begin
        err_flag <= dat_s2;
      end

      if (accept) begin
        busy_q <= 1'b1;
        err_q  <= 1'b0;
      end else if (finish) begin
        busy_q <= 1'b0;
        err_q  <= err;
      end
    end
  end

  assign busy       = busy_q;
  assign rx_inhibit = busy_q;
  assign done       = finish;
  assign err        = finish ? (timeout_hit | err_flag) : err_q;
  assign ps2_clk_oe = (state == INHIBIT) || (state == REQ);
  assign ps2_dat_oe = ~timeout_hit && ((state == REQ) || ((state == SEND) && dat_bit));

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain line model plus a behavioural
// keyboard that clocks the frame in, records the bits and optionally acknowledges.
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int TMO  = 3000;
  localparam int FLT  = 8;
  localparam int HALF = 40;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, err, rx_inhibit;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int inhib_cnt = 0;
  int rel_cyc = 0;
  int done_cyc = 0;
  logic       done_err = 1'b0;
  logic [1:0] done_oe = 2'b00;
  logic       prev_clk_oe = 1'b0;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILTER(FLT)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rx_inhibit (rx_inhibit),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  always #5 clk_sys = ~clk_sys;

  // Line monitor: inhibit length, clock release time and done-cycle snapshot.
  always @(negedge clk_sys) begin
    cyc++;
    if (ps2_clk_oe && !ps2_dat_oe) inhib_cnt++;
    if (prev_clk_oe && !ps2_clk_oe) rel_cyc = cyc;
    prev_clk_oe = ps2_clk_oe;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err;
      done_oe  = {ps2_clk_oe, ps2_dat_oe};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    @(negedge clk_sys);
    inhib_cnt = 0;
    tx_data   = data;
    tx_start  = 1'b1;
    @(negedge clk_sys);
    tx_start  = 1'b0;
  endtask

  // Keyboard model: start bit is seen when the host releases the clock, then ten
  // clock pulses sample d0..d7, parity, stop on rising edges, then the ack pulse.
  task automatic deviceFrame(input bit ack, input bit glitch, input int stop_after,
                             output logic [10:0] bits, output bit ok);
    int t;
    bits = '0;
    ok   = 1'b0;
    t    = 0;
    while (!(ps2_clk_in === 1'b1 && ps2_dat_in === 1'b0) && t < 2000) begin
      @(negedge clk_sys);
      t++;
    end
    if (t >= 2000) return;
    bits[0] = ps2_dat_in;
    repeat (HALF) @(negedge clk_sys);
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk_sys);
      dev_clk_low = 1'b0;
      @(negedge clk_sys);
      bits[i] = ps2_dat_in;
      if (i == stop_after) begin
        ok = 1'b1;
        return;
      end
      if (glitch) begin
        repeat (16) @(negedge clk_sys);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk_sys);
        dev_clk_low = 1'b0;
        repeat (HALF - 20) @(negedge clk_sys);
      end else begin
        repeat (HALF - 1) @(negedge clk_sys);
      end
    end
    if (ack) dev_dat_low = 1'b1;
    repeat (4) @(negedge clk_sys);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk_sys);
    dev_clk_low = 1'b0;
    repeat (4) @(negedge clk_sys);
    dev_dat_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic waitDone(input int base, input int limit, input string tag);
    int t;
    t = 0;
    while (done_cnt == base && t < limit) begin
      @(negedge clk_sys);
      t++;
    end
    repeat (3) @(negedge clk_sys);
    checkOutput({tag, " done pulses"}, done_cnt - base, 1);
  endtask

  task automatic runTransfer(input string tag, input logic [7:0] data, input logic par,
                             input bit ack, input bit glitch, input bit poke);
    logic [10:0] bits;
    bit          ok;
    int          base;
    base = done_cnt;
    applyStimulus(data);
    fork
      deviceFrame(ack, glitch, 0, bits, ok);
      begin
        if (poke) begin
          repeat (300) @(negedge clk_sys);
          tx_data  = 8'h55;
          tx_start = 1'b1;
          @(negedge clk_sys);
          tx_start = 1'b0;
        end
      end
    join
    checkOutput({tag, " device saw frame"}, 32'(ok), 1);
    checkOutput({tag, " frame bits"}, 32'(bits), 32'({1'b1, par, data, 1'b0}));
    waitDone(base, 2000, tag);
    checkOutput({tag, " inhibit cycles"}, inhib_cnt, INH);
    checkOutput({tag, " err at done"}, 32'(done_err), 32'(!ack));
    checkOutput({tag, " busy after"}, 32'(busy), 0);
    checkOutput({tag, " rx_inhibit after"}, 32'(rx_inhibit), 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [10:0] bits;
    bit          ok;
    int          base;

    repeat (4) @(negedge clk_sys);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset err", 32'(err), 0);
    checkOutput("reset oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk_sys);
    checkOutput("idle oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);

    runTransfer("ED", 8'hED, 1'b1, 1'b1, 1'b0, 1'b0);
    runTransfer("07", 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
    runTransfer("00", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    runTransfer("nack3C", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (50) @(negedge clk_sys);
    checkOutput("err holds", 32'(err), 1);

    // No device activity: the host must give up TMO cycles after releasing the clock.
    base = done_cnt;
    applyStimulus(8'h12);
    repeat (5) @(negedge clk_sys);
    checkOutput("err cleared on accept", 32'(err), 0);
    checkOutput("busy during", 32'(busy), 1);
    checkOutput("rx_inhibit during", 32'(rx_inhibit), 1);
    waitDone(base, INH + TMO + 500, "timeout");
    checkOutput("timeout latency", done_cyc - rel_cyc, TMO);
    checkOutput("timeout err", 32'(done_err), 1);
    checkOutput("timeout oe", 32'(done_oe), 0);
    checkOutput("timeout busy after", 32'(busy), 0);

    runTransfer("glitchA5", 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    base = done_cnt;
    repeat (400) @(negedge clk_sys);
    checkOutput("poke no second frame busy", 32'(busy), 0);
    checkOutput("poke no second done", done_cnt - base, 0);

    // Abort after the fourth data bit has been clocked out.
    applyStimulus(8'h5A);
    deviceFrame(1'b1, 1'b0, 4, bits, ok);
    checkOutput("abort partial bits", 32'(bits[4:0]), 32'(5'b10100));
    base = done_cnt;
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    checkOutput("abort oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    checkOutput("abort busy", 32'(busy), 0);
    repeat (30) @(negedge clk_sys);
    checkOutput("abort no done", done_cnt - base, 0);

    runTransfer("FF", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the sending side paired with the existing PS/2 keyboard receiver path.
- Sends one command byte at a time to the keyboard, e.g. LED set 0xED plus its data byte, or reset 0xFF, using the standard request-to-send sequence.
- Drives open-drain clock and data enables and checks the device acknowledge.
- While a transfer is in progress it asserts rx_inhibit, so the keyboard receiver ignores the line.

Parameters:
- INHIBIT_CYC, 9600: clk_sys cycles the host holds clock low before start; 100 us at 96 MHz.
- TIMEOUT_CYC, 1440000: maximum cycles from clock release to acknowledge; 15 ms at 96 MHz.
- FILTER, 8: consecutive equal samples required before the synchronised ps2_clk_in changes its filtered value.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- tx_data  in  8  byte to send; sampled when tx_start is accepted
- tx_start  in  1  single-cycle request; accepted only in IDLE
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse at end of a transfer
- err  out  1  valid with done: 1 = no acknowledge or timeout
- rx_inhibit  out  1  equals busy
- ps2_clk_in  in  1  raw line clock, asynchronous
- ps2_dat_in  in  1  raw line data, asynchronous
- ps2_clk_oe  out  1  1 = pull clock low
- ps2_dat_oe  out  1  1 = pull data low

Behaviour:
- Input conditioning: ps2_clk_in and ps2_dat_in each pass a 2-FF synchroniser. The clock then passes a FILTER-sample debouncer. fall = filtered clock 1->0 for one cycle.
- Reset: state IDLE; busy, done, err, ps2_clk_oe, ps2_dat_oe all 0; shift register and counters cleared. A reset mid-transfer releases both lines on the next edge; no done pulse.
- IDLE: when tx_start=1, latch shreg = {1'b1 stop, ~^tx_data odd parity, tx_data}, 10 bits, LSB sent first. Clear the cycle counter, set busy, go INHIBIT. tx_start while busy is ignored.
- INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0. After INHIBIT_CYC cycles, set ps2_dat_oe=1 (start bit) and go REQ.
- REQ: hold both oe=1 for 16 cycles, then ps2_clk_oe=0. Clear the timeout counter, bitcnt=0, go SEND.
- SEND: on each fall:
  - ps2_dat_oe = ~shreg[0], shift right, bitcnt+1.
  - The first fall presents data bit 0. The 9th fall presents parity. The 10th fall presents stop (oe=0).
  - After the 10th fall, go ACK.
- ACK: on the next fall, sample the synchronised data. 0 = ack OK; 1 = err_flag set. Go WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock = 1 and synchronised data = 1, then pulse done with err=err_flag, clear busy, go IDLE.
- Timeout: the counter runs in SEND, ACK and WAIT_IDLE. Reaching TIMEOUT_CYC forces both oe=0, done=1, err=1, and returns to IDLE in that cycle.
- err: holds its value until the next accepted tx_start clears it.
- Glitches shorter than FILTER cycles never produce fall.
- Counter widths: $clog2(param+1) bits. No wrap: each counter saturates at its terminal compare.
- done and tx_start in the same cycle: tx_start is ignored, because the state is not IDLE during that cycle.
- Throughput: at most one byte in flight. No queue; the caller waits for done.

Test Plan:
- Send 0xED with a device model acknowledging; the model clocks at 12 kHz. -> clock held low for exactly 9600 cycles. Bits sampled on rising edges are start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1. done=1 and err=0 once; busy then low.
- Send 0x07 -> parity bit 0. Send 0x00 -> parity bit 1. Both complete with err=0.
- Device never clocks after the request -> done=1 and err=1 exactly TIMEOUT_CYC cycles after clock release; both oe=0.
- Device clocks but leaves data high at the ack clock -> err=1 after the line returns idle.
- 3-cycle low glitches on the clock line during SEND -> no extra bit shifted; frame is correct. tx_start pulsed while busy -> ignored; single frame on the line.
- Reset asserted after the 4th data bit -> next cycle both oe=0, busy=0, no done pulse. A fresh tx_start of 0xFF then completes normally with parity 1.
